watch_time_ctrl: RTL

//  Timekeeping and set-mode controller for the 24 h digital watch.
//  - Sequences the HH:MM:SS BCD counter chain from an internal 1 Hz prescaler.
//  - Lets the user select a field (H, M, S) and adjust it with two pulse buttons.
//  - Performs the 23:59:59 -> 00:00:00 rollover itself and flags it with DAY_PULSE.
//  - Feeds the seven-segment decode path; BLINK drives blanking of the field being set.

---
 rtl/watch_time_ctrl_pkg.sv | 20 ++
 rtl/watch_time_ctrl_if.sv | 33 +++
 rtl/watch_time_ctrl_bcd_mod_counter.sv | 41 ++++
 rtl/watch_time_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/watch_time_ctrl_pkg.sv
// Shared types and limits for the watch timekeeping controller.
// Imported by the counter, the interface users and the top.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2,
    MODE_SET_S = 2'd3
  } mode_t;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/watch_time_ctrl_if.sv
// Button and display bundle between the watch front panel
// and the timekeeping controller.
interface watch_time_ctrl_if;

  logic       BTN_MODE;
  logic       BTN_INC;
  logic [3:0] BCD_H1;
  logic [3:0] BCD_H0;
  logic [3:0] BCD_M1;
  logic [3:0] BCD_M0;
  logic [3:0] BCD_S1;
  logic [3:0] BCD_S0;
  logic [1:0] MODE;
  logic       BLINK;
  logic       DAY_PULSE;

  modport master (
    output BTN_MODE, BTN_INC,
    input  BCD_H1, BCD_H0,
    input  BCD_M1, BCD_M0,
    input  BCD_S1, BCD_S0,
    input  MODE, BLINK, DAY_PULSE
  );

  modport slave (
    input  BTN_MODE, BTN_INC,
    output BCD_H1, BCD_H0,
    output BCD_M1, BCD_M0,
    output BCD_S1, BCD_S0,
    output MODE, BLINK, DAY_PULSE
  );

endinterface

// File: rtl/watch_time_ctrl_bcd_mod_counter.sv
// Two-digit BCD field counter, wraps from MAX to 00.
// carry is combinational: high when at MAX while inc is set.
module bcd_mod_counter
  import watch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       carry
);

  localparam logic [7:0] MAX_BCD = bcd8(MAX);

  logic at_max;

  assign at_max = ({d1, d0} == MAX_BCD);
  assign carry  = inc & at_max;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      d1 <= 4'd0;
      d0 <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        d1 <= 4'd0;
        d0 <= 4'd0;
      end else if (d0 == 4'd9) begin
        d1 <= d1 + 4'd1;
        d0 <= 4'd0;
      end else begin
        d0 <= d0 + 4'd1;
      end
    end
  end

endmodule

// File: rtl/watch_time_ctrl.sv
// 24 h watch controller: 1 Hz prescaler, HH:MM:SS chain,
// set-mode FSM with field blink and day rollover pulse.
module watch_time_ctrl
  import watch_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic         CLK,
  input  logic         RST,
  watch_time_ctrl_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  mode_t         state_q;
  mode_t         state_d;
  logic [PW-1:0] pre_q;
  logic [BW-1:0] blk_q;
  logic          blink_q;
  logic          day_q;

  logic run;
  logic tick;
  logic sec_inc;
  logic sec_clr;
  logic min_inc;
  logic hr_inc;
  logic set_h_inc;
  logic set_m_inc;
  logic sec_c;
  logic min_c;
  logic hr_c;

  logic [3:0] h1, h0, m1, m0, s1, s0;

  assign run  = (state_q == MODE_RUN);
  assign tick = run && (pre_q == PRE_LAST);

  // Mode entry wins over a coincident tick.
  assign sec_inc = tick && !bus.BTN_MODE;
  assign min_inc = run ? sec_c : set_m_inc;
  assign hr_inc  = run ? min_c : set_h_inc;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= MODE_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    set_h_inc = 1'b0;
    set_m_inc = 1'b0;
    sec_clr   = 1'b0;
    unique case (state_q)
      MODE_RUN: begin
        if (bus.BTN_MODE) state_d = MODE_SET_H;
      end
      MODE_SET_H: begin
        if (bus.BTN_MODE) state_d = MODE_SET_M;
        else set_h_inc = bus.BTN_INC;
      end
      MODE_SET_M: begin
        if (bus.BTN_MODE) state_d = MODE_SET_S;
        else set_m_inc = bus.BTN_INC;
      end
      MODE_SET_S: begin
        if (bus.BTN_MODE) state_d = MODE_RUN;
        else sec_clr = bus.BTN_INC;
      end
      default: state_d = MODE_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || !run || bus.BTN_MODE || tick)
      pre_q <= '0;
    else
      pre_q <= pre_q + PW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST || run || bus.BTN_MODE) begin
      blk_q   <= '0;
      blink_q <= 1'b0;
    end else if (blk_q == BLK_LAST) begin
      blk_q   <= '0;
      blink_q <= ~blink_q;
    end else begin
      blk_q <= blk_q + BW'(1);
    end
  end

  // Hour carry only reaches here in RUN on the full rollover.
  always_ff @(posedge CLK) begin
    if (RST) day_q <= 1'b0;
    else     day_q <= hr_c && run;
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (sec_inc),
    .clr   (sec_clr),
    .d1    (s1),
    .d0    (s0),
    .carry (sec_c)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (min_inc),
    .clr   (1'b0),
    .d1    (m1),
    .d0    (m0),
    .carry (min_c)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hr (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (hr_inc),
    .clr   (1'b0),
    .d1    (h1),
    .d0    (h0),
    .carry (hr_c)
  );

  assign bus.BCD_H1    = h1;
  assign bus.BCD_H0    = h0;
  assign bus.BCD_M1    = m1;
  assign bus.BCD_M0    = m0;
  assign bus.BCD_S1    = s1;
  assign bus.BCD_S0    = s0;
  assign bus.MODE      = state_q;
  assign bus.BLINK     = blink_q;
  assign bus.DAY_PULSE = day_q;

endmodule
